// File: rtl/d_delay_line.sv
// Stallable multi-stage register delay line with per-stage valid bits,
// synchronous flush and a runtime-selectable output tap.
module d_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int SELW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic [SELW-1:0]  delay_sel,
  output logic [WIDTH-1:0] qout,
  output logic             qout_valid,
  output logic             cfg_err
);

  // Index 0 is stage 1 (nearest the input), index DEPTH-1 is stage DEPTH.
  logic [WIDTH-1:0] stage_reg  [DEPTH];
  logic [WIDTH-1:0] stage_next [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;
  logic             cfg_err_reg;
  logic             sel_illegal;
  logic [SELW-1:0]  eff_sel;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_next[gi] = d;
      end else begin : g_body
        assign stage_next[gi] = stage_reg[gi-1];
      end
    end
  endgenerate

  assign valid_next = {valid_reg[DEPTH-2:0], d_valid};

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) stage_reg[k] <= '0;
      valid_reg <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) stage_reg[k] <= '0;
      valid_reg <= '0;
    end else if (en) begin
      for (int k = 0; k < DEPTH; k++) stage_reg[k] <= stage_next[k];
      valid_reg <= valid_next;
    end
  end

  assign sel_illegal = (delay_sel == '0) || (delay_sel > SELW'(DEPTH));

  // Sticky: only reset clears it, and it is evaluated even when stalled or flushing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cfg_err_reg <= 1'b0;
    end else if (sel_illegal) begin
      cfg_err_reg <= 1'b1;
    end
  end

  assign cfg_err = cfg_err_reg;

  always_comb begin
    eff_sel = delay_sel;
    if (delay_sel == '0) begin
      eff_sel = SELW'(1);
    end else if (delay_sel > SELW'(DEPTH)) begin
      eff_sel = SELW'(DEPTH);
    end
  end

  // Combinational tap straight from the stage registers; the tap can move any cycle.
  always_comb begin
    qout       = '0;
    qout_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (eff_sel == SELW'(k + 1)) begin
        qout       = stage_reg[k];
        qout_valid = valid_reg[k];
      end
    end
  end

endmodule

// File: tb/tb_d_delay_line.sv
// Scoreboard bench for d_delay_line: stimulus pushes hand-derived expectations,
// a monitor pops and compares one entry after every clock edge.
module tb_d_delay_line;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int SELW  = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic             d_valid = 1'b0;
  logic [SELW-1:0]  delay_sel = SELW'(1);
  logic [WIDTH-1:0] qout;
  logic             qout_valid;
  logic             cfg_err;

  d_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SELW(SELW)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
    .delay_sel(delay_sel), .qout(qout), .qout_valid(qout_valid), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit             chk;
    logic [WIDTH-1:0] q;
    logic           v;
    logic           err;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests_run = 0;
  int    tests_failed = 0;
  logic  err_exp = 1'b0;

  // Drive one cycle of inputs before the next rising edge and queue what the
  // outputs must show just after that edge.
  task automatic step(input logic r, input logic f, input logic e,
                      input logic [WIDTH-1:0] dd, input logic dv,
                      input logic [SELW-1:0] sel, input bit chk,
                      input logic [WIDTH-1:0] eq, input logic ev, input string nm);
    exp_t x;
    @(negedge clk);
    rst = r; flush = f; en = e; d = dd; d_valid = dv; delay_sel = sel;
    x.chk = chk; x.q = eq; x.v = ev; x.err = err_exp;
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  // Stream nwords valid words base..base+nwords-1 into an empty chain at a fixed
  // tap; word m (sampled at step m) must show after step m+sel-1.
  task automatic run_stream(input int sel, input int nwords, input int base, input string nm);
    for (int n = 1; n <= nwords + sel; n++) begin
      int m;
      logic [WIDTH-1:0] dd;
      m  = n - sel + 1;
      dd = (n <= nwords) ? WIDTH'(base + n - 1) : '0;
      if (m >= 1 && m <= nwords)
        step(1, 0, 1, dd, n <= nwords, SELW'(sel), 1, WIDTH'(base + m - 1), 1'b1, nm);
      else
        step(1, 0, 1, dd, n <= nwords, SELW'(sel), 1, '0, 1'b0, nm);
    end
  endtask

  task automatic do_flush(input string nm);
    step(1, 1, 0, '0, 0, SELW'(1), 1, '0, 1'b0, nm);
  endtask

  initial begin : monitor
    exp_t  x;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (x.chk) begin
          tests_run++;
          if (qout !== x.q || qout_valid !== x.v || cfg_err !== x.err) begin
            tests_failed++;
            $display("FAIL %s: got qout=%h valid=%b cfg_err=%b, expected qout=%h valid=%b cfg_err=%b",
                     nm, qout, qout_valid, cfg_err, x.q, x.v, x.err);
          end else begin
            $display("[TB] ok %s: qout=%h valid=%b cfg_err=%b", nm, qout, qout_valid, cfg_err);
          end
        end
      end
    end
  end

  initial begin : stimulus
    // Reset held two edges with live input traffic.
    step(0, 0, 1, 8'hFF, 1, SELW'(1), 1, '0, 1'b0, "reset_hold1");
    step(0, 0, 1, 8'hFF, 1, SELW'(1), 1, '0, 1'b0, "reset_hold2");

    // Fixed delays 3, 1 and DEPTH.
    run_stream(3, 5, 1, "delay3");
    do_flush("flush_pre_d1");
    run_stream(1, 5, 8'h21, "delay1");
    do_flush("flush_pre_d8");
    run_stream(8, 5, 8'h41, "delay8");

    // Stall: A5 captured, one advance, three stalls (peeked at tap 2), then on to tap 4.
    do_flush("flush_pre_stall");
    step(1, 0, 1, 8'hA5, 1, SELW'(4), 1, '0, 1'b0, "stall_cap");
    step(1, 0, 1, 8'h00, 0, SELW'(4), 1, '0, 1'b0, "stall_adv2");
    step(1, 0, 0, 8'h11, 1, SELW'(2), 1, 8'hA5, 1'b1, "stall_hold1");
    step(1, 0, 0, 8'h22, 1, SELW'(2), 1, 8'hA5, 1'b1, "stall_hold2");
    step(1, 0, 0, 8'h33, 1, SELW'(2), 1, 8'hA5, 1'b1, "stall_hold3");
    step(1, 0, 1, 8'h00, 0, SELW'(4), 1, '0, 1'b0, "stall_adv3");
    step(1, 0, 1, 8'h00, 0, SELW'(4), 1, 8'hA5, 1'b1, "stall_out");
    step(1, 0, 1, 8'h00, 0, SELW'(4), 1, '0, 1'b0, "stall_after");

    // Flush with en=1 and d=77 on the same edge.
    for (int n = 1; n <= 8; n++)
      step(1, 0, 1, WIDTH'(8'h30 + n), 1, SELW'(8), n == 8, 8'h31, 1'b1, "flush_fill");
    step(1, 1, 1, 8'h77, 1, SELW'(1), 1, '0, 1'b0, "flush_tap1");
    step(1, 0, 0, 8'h00, 0, SELW'(8), 1, '0, 1'b0, "flush_tap8");
    step(1, 0, 1, 8'h00, 0, SELW'(2), 1, '0, 1'b0, "flush_no77");

    // Tap change mid-stream: 10..17 at tap 2, then peek taps 6 and 2 while stalled.
    do_flush("flush_pre_tap");
    for (int n = 1; n <= 8; n++) begin
      if (n == 1) step(1, 0, 1, 8'd10, 1, SELW'(2), 1, '0, 1'b0, "tap_stream");
      else        step(1, 0, 1, WIDTH'(9 + n), 1, SELW'(2), 1, WIDTH'(8 + n), 1'b1, "tap_stream");
    end
    step(1, 0, 0, 8'h00, 0, SELW'(6), 1, 8'd12, 1'b1, "tap_to6");
    step(1, 0, 0, 8'h00, 0, SELW'(2), 1, 8'd16, 1'b1, "tap_back2");

    // Illegal selects: chain holds s1=17 .. s8=10.
    err_exp = 1'b1;
    step(1, 0, 0, 8'h00, 0, SELW'(0), 1, 8'd17, 1'b1, "sel0_as1");
    step(1, 0, 0, 8'h00, 0, SELW'(9), 1, 8'd10, 1'b1, "sel9_as8");
    step(1, 0, 0, 8'h00, 0, SELW'(15), 1, 8'd10, 1'b1, "sel15_as8");
    step(1, 0, 0, 8'h00, 0, SELW'(5), 1, 8'd13, 1'b1, "err_sticky");
    step(1, 1, 1, 8'h55, 1, SELW'(5), 1, '0, 1'b0, "err_kept_flush");
    err_exp = 1'b0;
    step(0, 0, 1, 8'h00, 0, SELW'(0), 1, '0, 1'b0, "reset_beats_sel0");
    step(1, 0, 1, 8'h66, 1, SELW'(1), 1, 8'h66, 1'b1, "post_reset_d1");
    step(1, 0, 1, 8'h67, 1, SELW'(1), 1, 8'h67, 1'b1, "post_reset_d1b");

    // Mid-stream reset loses words in flight.
    step(0, 0, 1, 8'h99, 1, SELW'(2), 1, '0, 1'b0, "reset_midstream");
    step(1, 0, 1, 8'h00, 0, SELW'(2), 1, '0, 1'b0, "reset_nothing_left");

    repeat (3) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
